// File: rtl/slice_arbiter.sv
// slice_arbiter: round-robin time-slice arbiter for one shared counted resource.
// A grant lasts at most SLICE_CNT enabled cycles and ends early when the holder
// drops its request or signals done. Consecutive grants are always separated by
// one turnaround (GAP) cycle. All outputs come straight from flops.
module slice_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int SLICE_CNT = 8
) (
   input  logic                             clkIn,
   input  logic                             rstIn,
   input  logic                             enIn,
   input  logic [NUM_REQ-1:0]               reqIn,
   input  logic [NUM_REQ-1:0]               doneIn,
   output logic [NUM_REQ-1:0]               grantOut,
   output logic [$clog2(NUM_REQ)-1:0]       grantIdxOut,
   output logic                             busyOut,
   output logic                             sliceExpOut,
   output logic [$clog2(SLICE_CNT+1)-1:0]   sliceCntOut
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(SLICE_CNT + 1);

   localparam logic [CW-1:0]      CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]      CNT_FULL  = CW'(SLICE_CNT);
   localparam logic [NUM_REQ-1:0] GRANT_NONE = {NUM_REQ{1'b0}};
   localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);
   localparam logic [IW-1:0]      IDX_ZERO   = {IW{1'b0}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // (base + offs) modulo NUM_REQ; offs is always below NUM_REQ.
   function automatic logic [IW-1:0] wrapIdx(input logic [IW-1:0] base, input int offs);
      int s;
      s = int'(base) + offs;
      if (s >= NUM_REQ) begin
         s = s - NUM_REQ;
      end else begin
         s = s;
      end
      return IW'(s);
   endfunction

   state_t               stateR, stateNext;
   logic [IW-1:0]        ptrR, ptrNext;
   logic [NUM_REQ-1:0]   grantR, grantNext;
   logic [IW-1:0]        idxR, idxNext;
   logic [CW-1:0]        cntR, cntNext;
   logic                 busyR, busyNext;
   logic                 expR, expNext;

   logic                 hasWin;
   logic [IW-1:0]        winIdx;
   logic                 dropEnd;
   logic                 expEnd;
   logic                 grantEnd;

   // Round-robin search: first requesting index at or after ptrR, wrapping.
   always_comb begin
      hasWin = 1'b0;
      winIdx = IDX_ZERO;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!hasWin && reqIn[wrapIdx(ptrR, k)]) begin
            hasWin = 1'b1;
            winIdx = wrapIdx(ptrR, k);
         end else begin
            hasWin = hasWin;
            winIdx = winIdx;
         end
      end
   end

   // End-of-grant causes for the current holder; drop/done outrank expiry.
   always_comb begin
      dropEnd  = (~reqIn[idxR]) | doneIn[idxR];
      expEnd   = enIn & (cntR == CNT_ONE);
      grantEnd = dropEnd | expEnd;
   end

   // State register.
   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         stateR <= IDLE;
      end else begin
         stateR <= stateNext;
      end
   end

   // Next-state logic.
   always_comb begin
      stateNext = stateR;
      case (stateR)
         IDLE, GAP: begin
            if (enIn && hasWin) begin
               stateNext = GRANT;
            end else begin
               stateNext = IDLE;
            end
         end
         GRANT: begin
            if (grantEnd) begin
               stateNext = GAP;
            end else begin
               stateNext = GRANT;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Next values of the registered outputs and round-robin pointer.
   always_comb begin
      grantNext = grantR;
      idxNext   = idxR;
      cntNext   = cntR;
      ptrNext   = ptrR;
      busyNext  = busyR;
      expNext   = 1'b0;
      case (stateR)
         IDLE, GAP: begin
            if (enIn && hasWin) begin
               grantNext = ONE_HOT0 << winIdx;
               idxNext   = winIdx;
               cntNext   = CNT_FULL;
               busyNext  = 1'b1;
            end else begin
               grantNext = GRANT_NONE;
               cntNext   = CNT_ZERO;
               busyNext  = 1'b0;
            end
         end
         GRANT: begin
            if (grantEnd) begin
               grantNext = GRANT_NONE;
               cntNext   = CNT_ZERO;
               busyNext  = 1'b0;
               ptrNext   = wrapIdx(idxR, 1);
               expNext   = expEnd & ~dropEnd;
            end else if (enIn) begin
               cntNext   = cntR - CNT_ONE;
            end else begin
               cntNext   = cntR;
            end
         end
         default: begin
            grantNext = GRANT_NONE;
            cntNext   = CNT_ZERO;
            busyNext  = 1'b0;
         end
      endcase
   end

   // Output and pointer registers.
   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         grantR <= GRANT_NONE;
         idxR   <= IDX_ZERO;
         cntR   <= CNT_ZERO;
         ptrR   <= IDX_ZERO;
         busyR  <= 1'b0;
         expR   <= 1'b0;
      end else begin
         grantR <= grantNext;
         idxR   <= idxNext;
         cntR   <= cntNext;
         ptrR   <= ptrNext;
         busyR  <= busyNext;
         expR   <= expNext;
      end
   end

   assign grantOut    = grantR;
   assign grantIdxOut = idxR;
   assign busyOut     = busyR;
   assign sliceExpOut = expR;
   assign sliceCntOut = cntR;

endmodule

// File: tb/tb_slice_arbiter.sv
// Directed bench for slice_arbiter (NUM_REQ=4, SLICE_CNT=8) with hand-computed
// expected values for rotation, single requester, done, enable gating,
// done/expiry coincidence and asynchronous reset mid-grant.
module tb_slice_arbiter;

   logic       clkIn;
   logic       rstIn;
   logic       enIn;
   logic [3:0] reqIn;
   logic [3:0] doneIn;
   logic [3:0] grantOut;
   logic [1:0] grantIdxOut;
   logic       busyOut;
   logic       sliceExpOut;
   logic [3:0] sliceCntOut;

   int errors = 0;
   int checks = 0;

   slice_arbiter #(.NUM_REQ(4), .SLICE_CNT(8)) dut (
      .clkIn       (clkIn),
      .rstIn       (rstIn),
      .enIn        (enIn),
      .reqIn       (reqIn),
      .doneIn      (doneIn),
      .grantOut    (grantOut),
      .grantIdxOut (grantIdxOut),
      .busyOut     (busyOut),
      .sliceExpOut (sliceExpOut),
      .sliceCntOut (sliceCntOut)
   );

   // 10 ns clock.
   initial clkIn = 1'b0;
   always #5 clkIn = ~clkIn;

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock; land 1 ns after the rising edge.
   task automatic cyc();
      @(posedge clkIn);
      #1;
   endtask

   // Check an idle/gap cycle.
   task automatic checkNoGrant(input string tag, input logic expPulse);
      checkEq({tag, ".grant"}, 32'(grantOut), 32'd0);
      checkEq({tag, ".busy"},  32'(busyOut), 32'd0);
      checkEq({tag, ".cnt"},   32'(sliceCntOut), 32'd0);
      checkEq({tag, ".exp"},   32'(sliceExpOut), 32'(expPulse));
   endtask

   // Starting on the first cycle of a grant to idx: check a full 8-cycle slice,
   // the expiry gap cycle, then step onto the next grant's first cycle.
   task automatic fullSlice(input string tag, input int idx);
      for (int k = 0; k < 8; k++) begin
         checkEq({tag, ".grant"}, 32'(grantOut), 32'(4'b0001 << idx));
         checkEq({tag, ".idx"},   32'(grantIdxOut), 32'(idx));
         checkEq({tag, ".cnt"},   32'(sliceCntOut), 32'(8 - k));
         checkEq({tag, ".busy"},  32'(busyOut), 32'd1);
         checkEq({tag, ".noexp"}, 32'(sliceExpOut), 32'd0);
         cyc();
      end
      checkNoGrant({tag, ".gap"}, 1'b1);
      cyc();
   endtask

   initial begin
      rstIn  = 1'b1;
      enIn   = 1'b0;
      reqIn  = 4'b0000;
      doneIn = 4'b0000;
      #12;
      checkNoGrant("reset", 1'b0);
      checkEq("reset.idx", 32'(grantIdxOut), 32'd0);

      // Rotation with all four requesting.
      reqIn = 4'b1111;
      enIn  = 1'b1;
      @(posedge clkIn);
      #1;
      rstIn = 1'b0;
      cyc();
      fullSlice("rot0", 0);
      fullSlice("rot1", 1);
      fullSlice("rot2", 2);
      fullSlice("rot3", 3);
      checkEq("rot.wrap", 32'(grantOut), 32'b0001);

      // Single requester 2: holder 0 drops, then repeated slices to 2.
      reqIn = 4'b0100;
      cyc();
      checkNoGrant("drop0", 1'b0);
      cyc();
      fullSlice("single2a", 2);
      fullSlice("single2b", 2);
      checkEq("single2.again", 32'(grantOut), 32'b0100);

      // Holder 1 signals done on its 3rd cycle.
      reqIn = 4'b0010;
      cyc();
      checkNoGrant("drop2", 1'b0);
      cyc();
      checkEq("done.g1", 32'(grantOut), 32'b0010);
      checkEq("done.c1", 32'(sliceCntOut), 32'd8);
      cyc();
      checkEq("done.c2", 32'(sliceCntOut), 32'd7);
      cyc();
      checkEq("done.c3", 32'(sliceCntOut), 32'd6);
      doneIn = 4'b0010;
      reqIn  = 4'b1010;
      cyc();
      checkNoGrant("done.gap", 1'b0);
      checkEq("done.idxHold", 32'(grantIdxOut), 32'd1);
      doneIn = 4'b0000;
      cyc();
      checkEq("done.next", 32'(grantOut), 32'b1000);
      checkEq("done.nextIdx", 32'(grantIdxOut), 32'd3);
      reqIn = 4'b0000;
      cyc();
      cyc();
      checkNoGrant("toIdle", 1'b0);

      // Enable gating: no grant with enIn=0, then alternating enable in a grant.
      enIn  = 1'b0;
      reqIn = 4'b0001;
      cyc();
      cyc();
      checkNoGrant("enLow", 1'b0);
      enIn = 1'b1;
      cyc();
      for (int k = 0; k < 15; k++) begin
         checkEq("enTog.grant", 32'(grantOut), 32'b0001);
         checkEq("enTog.cnt", 32'(sliceCntOut), 32'(8 - (k + 1) / 2));
         enIn = (k % 2 == 0) ? 1'b1 : 1'b0;
         cyc();
      end
      checkNoGrant("enTog.end", 1'b1);
      reqIn = 4'b0000;
      cyc();
      checkNoGrant("enTog.idle", 1'b0);

      // Done coincident with the last enabled cycle: no expiry pulse.
      enIn  = 1'b1;
      reqIn = 4'b0001;
      cyc();
      checkEq("coin.grant", 32'(grantOut), 32'b0001);
      for (int k = 0; k < 7; k++) begin
         cyc();
      end
      checkEq("coin.cnt1", 32'(sliceCntOut), 32'd1);
      doneIn = 4'b0001;
      cyc();
      checkNoGrant("coin.gap", 1'b0);
      doneIn = 4'b0000;
      reqIn  = 4'b0000;
      cyc();

      // Asynchronous reset in the middle of a grant to idx 3.
      reqIn = 4'b1000;
      cyc();
      checkEq("rst.grant3", 32'(grantOut), 32'b1000);
      checkEq("rst.idx3", 32'(grantIdxOut), 32'd3);
      cyc();
      cyc();
      rstIn = 1'b1;
      #1;
      checkNoGrant("rst.mid", 1'b0);
      checkEq("rst.midIdx", 32'(grantIdxOut), 32'd0);
      reqIn = 4'b1001;
      rstIn = 1'b0;
      cyc();
      checkEq("rst.after", 32'(grantOut), 32'b0001);
      checkEq("rst.afterIdx", 32'(grantIdxOut), 32'd0);
      checkEq("rst.afterCnt", 32'(sliceCntOut), 32'd8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
